// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the NPC memory arbiter: FSM state codes, owner encoding
// and the round-robin pick used when both the IFU and the LSU request at once.
package ysyx_24100005_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_REQ  = 2'd1;
  localparam arb_state_t ARB_WAIT = 2'd2;
  localparam arb_state_t ARB_RESP = 2'd3;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // On a tie the requester that did not win the previous grant is chosen.
  function automatic owner_t rr_pick(input logic ifu_v, input logic lsu_v, input owner_t last);
    owner_t pick;
    if (ifu_v && lsu_v) begin
      if (last == OWN_LSU) pick = OWN_IFU;
      else                 pick = OWN_LSU;
    end else if (lsu_v) begin
      pick = OWN_LSU;
    end else begin
      pick = OWN_IFU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single NPC memory port between the IFU and the LSU, one transaction at a time,
// round-robin on contention, with a sticky timeout flag for a memory that never answers.
module ysyx_24100005_mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_timeout
);
  import ysyx_24100005_pkg::*;

  localparam int CW = $clog2(TO_MAX + 1);

  arb_state_t      state;
  owner_t          owner;
  owner_t          last_grant;
  owner_t          pick;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [CW-1:0]   to_cnt;
  logic            capture;

  // Ready is only offered in IDLE, and only to the requester the round-robin picks.
  always_comb begin
    pick          = rr_pick(ifu_req_valid, lsu_req_valid, last_grant);
    ifu_req_ready = (state == ARB_IDLE) && ifu_req_valid && (pick == OWN_IFU);
    lsu_req_ready = (state == ARB_IDLE) && lsu_req_valid && (pick == OWN_LSU);
    capture       = mem_rsp_valid &&
                    (((state == ARB_REQ) && mem_req_ready) || (state == ARB_WAIT));
  end

  assign mem_req_valid = (state == ARB_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = (state == ARB_RESP) && (owner == OWN_IFU);
  assign lsu_rsp_valid = (state == ARB_RESP) && (owner == OWN_LSU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= OWN_IFU;
      last_grant  <= OWN_LSU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      to_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (ifu_req_ready) begin
            addr_q     <= ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            state      <= ARB_REQ;
          end else if (lsu_req_ready) begin
            addr_q     <= lsu_addr;
            wen_q      <= lsu_wen;
            wdata_q    <= lsu_wdata;
            wmask_q    <= lsu_wmask;
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            state      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            to_cnt <= '0;
            state  <= mem_rsp_valid ? ARB_RESP : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // The counter saturates; the FSM keeps waiting so a late response is still delivered.
          if (mem_rsp_valid) begin
            state <= ARB_RESP;
          end else if (to_cnt != CW'(TO_MAX)) begin
            to_cnt <= to_cnt + CW'(1);
            if (to_cnt == CW'(TO_MAX - 1)) mem_timeout <= 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else if (capture) begin
      if (owner == OWN_IFU) ifu_rdata <= mem_rdata;
      else                  lsu_rdata <= wen_q ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model.
module tb_ysyx_24100005_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO_MAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_lsu = 1'b1;

  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter #(.AW(AW), .DW(DW), .TO_MAX(TO_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr  = '0;
    lsu_req_valid = 1'b0; lsu_addr  = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_lsu = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    logic [138:0] outs;
    idle_inputs();
    rst = 1'b1;
    #3;
    outs = {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen,
            mem_timeout, mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", outs);
    end
    tick();
    rst = 1'b0;
    last_lsu = 1'b1;
    settle();
  endtask

  task automatic test_ifu_alone();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    settle();
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL ifu_alone_ready: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 1'b0;
    settle();
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_wen, ifu_rsp_valid} !== {1'b1, 32'h8000_0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL ifu_alone_req: got %h, expected %h",
               {mem_req_valid, mem_addr, mem_wen, ifu_rsp_valid}, {1'b1, 32'h8000_0000, 1'b0, 1'b0});
    end
    tick();
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata} !== {2'b10, 32'h0000_0413}) begin
      n_fail++;
      $display("[TB] FAIL ifu_alone_rsp: got %h, expected %h",
               {ifu_rsp_valid, lsu_rsp_valid, ifu_rdata}, {2'b10, 32'h0000_0413});
    end
    ifu_req_valid = 1'b1;
    settle();
    n_checks++;
    if (ifu_req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ifu_no_ready_in_resp: got %b, expected 0", ifu_req_ready);
    end
    tick();
    n_checks++;
    if ({ifu_req_ready, ifu_rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL ifu_regrant_t3: got %b, expected 10", {ifu_req_ready, ifu_rsp_valid});
    end
    idle_inputs();
    settle();
  endtask

  task automatic test_tie();
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    settle();
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL tie_first_ifu: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 1'b0;
    settle();
    n_checks++;
    if (mem_addr !== 32'h8000_0010) begin
      n_fail++;
      $display("[TB] FAIL tie_first_addr: got %h, expected 80000010", mem_addr);
    end
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0014;
    settle();
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL tie_first_rsp: got %b, expected 10", {ifu_rsp_valid, lsu_rsp_valid});
    end
    tick();
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL tie_second_lsu: got %b, expected 01", {ifu_req_ready, lsu_req_ready});
    end
    mem_rdata = 32'h2222_2222;
    tick();
    lsu_req_valid = 1'b0;
    settle();
    n_checks++;
    if ({mem_addr, mem_wen} !== {32'h8000_2000, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL tie_second_addr: got %h, expected %h", {mem_addr, mem_wen}, {32'h8000_2000, 1'b0});
    end
    tick();
    lsu_req_valid = 1'b1;
    settle();
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, lsu_rdata} !== {2'b01, 32'h2222_2222}) begin
      n_fail++;
      $display("[TB] FAIL tie_second_rsp: got %h, expected %h",
               {ifu_rsp_valid, lsu_rsp_valid, lsu_rdata}, {2'b01, 32'h2222_2222});
    end
    tick();
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL tie_third_ifu: got %b, expected 10", {ifu_req_ready, lsu_req_ready});
    end
    idle_inputs();
    settle();
  endtask

  task automatic test_store();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    mem_req_ready = 1'b1;
    settle();
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL store_ready: got %b, expected 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0;
    settle();
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
        {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
      n_fail++;
      $display("[TB] FAIL store_payload: got %h, expected %h",
               {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask},
               {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, lsu_rdata} !== {2'b01, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL store_rsp: got %h, expected %h", {ifu_rsp_valid, lsu_rsp_valid, lsu_rdata}, {2'b01, 32'h0});
    end
    tick();
    n_checks++;
    if (lsu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_rsp_pulse: got %b, expected 0", lsu_rsp_valid);
    end
    idle_inputs();
    settle();
  endtask

  task automatic test_backpressure();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    settle();
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_5000; ifu_addr = 32'h8000_0104;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_checks++;
      if ({mem_req_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wen} !==
          {3'b100, 32'h8000_0100, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL backpressure_hold[%0d]: got %h, expected %h", i,
                 {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wen}, {3'b100, 32'h8000_0100, 1'b0});
      end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata} !== {2'b10, 32'h0010_0073}) begin
      n_fail++;
      $display("[TB] FAIL backpressure_rsp: got %h, expected %h",
               {ifu_rsp_valid, lsu_rsp_valid, ifu_rdata}, {2'b10, 32'h0010_0073});
    end
    tick();
  endtask

  task automatic test_timeout();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    tick();
    lsu_req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    repeat (TO_MAX - 2) tick();
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_early: got %b, expected 0", mem_timeout);
    end
    repeat (4) tick();
    n_checks++;
    if ({mem_timeout, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL timeout_raised: got %b, expected 1000",
               {mem_timeout, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    n_checks++;
    if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rdata, mem_timeout} !== {2'b10, 32'h55AA_55AA, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL timeout_late_rsp: got %h, expected %h",
               {lsu_rsp_valid, ifu_rsp_valid, lsu_rdata, mem_timeout}, {2'b10, 32'h55AA_55AA, 1'b1});
    end
    tick();
    tick();
    n_checks++;
    if (mem_timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_sticky: got %b, expected 1", mem_timeout);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [138:0] outs;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    mem_req_ready = 1'b1;
    settle();
    tick();
    ifu_req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    outs = {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen,
            mem_timeout, mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_outputs: got %h, expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    last_lsu = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_ignore[%0d]: got %b, expected 000", i,
                 {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
      end
    end
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
    mem_req_ready = 1'b1; mem_rdata = 32'h0000_0513;
    settle();
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_next_ready: got %b, expected 1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0;
    tick();
    n_checks++;
    if ({lsu_rsp_valid, lsu_rdata} !== {1'b1, 32'h0000_0513}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_next_rsp: got %h, expected %h", {lsu_rsp_valid, lsu_rdata}, {1'b1, 32'h0000_0513});
    end
    idle_inputs();
    tick();
  endtask

  // Random traffic: each side keeps its request pending until granted; the model is just
  // "on a tie, the side that did not win last time goes next".
  task automatic test_random();
    bit          pend_ifu = 1'b0;
    bit          pend_lsu = 1'b0;
    bit          lsu_wins;
    bit          rsp_now;
    logic [68:0] exp_pay;
    logic [31:0] rdata;
    int          stall;
    int          waits;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      if (!pend_ifu && $urandom_range(0, 1) == 1) begin
        pend_ifu = 1'b1; ifu_addr = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
      end
      if (!pend_lsu && $urandom_range(0, 1) == 1) begin
        pend_lsu = 1'b1; lsu_addr = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
        lsu_wen = 1'($urandom_range(0, 1)); lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      if (!pend_ifu && !pend_lsu) begin
        pend_ifu = 1'b1; ifu_addr = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
      end
      ifu_req_valid = pend_ifu; lsu_req_valid = pend_lsu;
      settle();
      lsu_wins = pend_lsu && (!pend_ifu || !last_lsu);
      n_checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {!lsu_wins, lsu_wins}) begin
        n_fail++;
        $display("[TB] FAIL rand_grant[%0d]: got %b, expected %b", it,
                 {ifu_req_ready, lsu_req_ready}, {!lsu_wins, lsu_wins});
      end
      exp_pay  = lsu_wins ? {lsu_addr, lsu_wen, lsu_wdata, lsu_wmask} : {ifu_addr, 1'b0, 32'h0, 4'h0};
      last_lsu = lsu_wins;
      tick();
      if (lsu_wins) begin pend_lsu = 1'b0; lsu_req_valid = 1'b0; end
      else          begin pend_ifu = 1'b0; ifu_req_valid = 1'b0; end
      stall = $urandom_range(0, 2);
      rsp_now = 1'($urandom_range(0, 1));
      rdata = $urandom;
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) begin
          mem_req_ready = 1'b1; mem_rsp_valid = rsp_now; mem_rdata = rdata;
        end
        settle();
        n_checks++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
            {3'b100, exp_pay}) begin
          n_fail++;
          $display("[TB] FAIL rand_req_payload[%0d]: got %h, expected %h", it,
                   {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_addr, mem_wen, mem_wdata, mem_wmask},
                   {3'b100, exp_pay});
        end
        tick();
      end
      mem_req_ready = 1'b0;
      if (!rsp_now) begin
        mem_rsp_valid = 1'b0;
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
          settle();
          n_checks++;
          if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL rand_wait[%0d]: got %b, expected 000", it,
                     {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
          end
          tick();
        end
        mem_rsp_valid = 1'b1;
        tick();
      end
      mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      settle();
      n_checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready} !== {!lsu_wins, lsu_wins, 2'b00}) begin
        n_fail++;
        $display("[TB] FAIL rand_rsp_owner[%0d]: got %b, expected %b", it,
                 {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, {!lsu_wins, lsu_wins, 2'b00});
      end
      n_checks++;
      if (lsu_wins && lsu_rdata !== (lsu_wen ? 32'h0 : rdata)) begin
        n_fail++;
        $display("[TB] FAIL rand_lsu_rdata[%0d]: got %h, expected %h", it, lsu_rdata, lsu_wen ? 32'h0 : rdata);
      end else if (!lsu_wins && ifu_rdata !== rdata) begin
        n_fail++;
        $display("[TB] FAIL rand_ifu_rdata[%0d]: got %h, expected %h", it, ifu_rdata, rdata);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_ifu_alone();
    test_tie();
    test_store();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
